// File: rtl/rsff_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// rsff_ctrl_pkg : shared state and operation encodings for the RS-FF arbiter
// Revision: 1.0
// ============================================================================
package rsff_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_RECOVER = 2'd2,
    ST_CHECK   = 2'd3
  } state_t;

  localparam logic OP_RESET = 1'b0;
  localparam logic OP_SET   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// rr_arb2 : combinational 2-way round-robin arbiter; pointer register is external
// Revision: 1.0
// ============================================================================
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant,
  output logic       ptr_next
);

  always_comb begin
    grant    = 2'b00;
    ptr_next = ptr;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
    // The pointer always moves to the requester that did not just win.
    if (|req) ptr_next = ~grant[1];
  end

endmodule
`default_nettype wire

// File: rtl/rsff_req_arbiter.sv
`default_nettype none
// ============================================================================
// rsff_req_arbiter : shares one clocked RS flip-flop between two requesters
// Revision: 1.0
// ============================================================================
module rsff_req_arbiter
  import rsff_ctrl_pkg::*;
#(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] op,
  input  logic       Q,
  input  logic       nQ,
  output logic       S,
  output logic       R,
  output logic [1:0] gnt,
  output logic       done,
  output logic       err,
  output logic       busy
);

  localparam bit              HAS_GAP  = (GAP_W > 0);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = (GAP_W > 0) ? CNT_W'(GAP_W - 1) : '0;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             ptr, ptr_n;
  logic             op_lat, op_lat_n;
  logic             s_n, r_n, done_n, err_n, busy_n;
  logic [1:0]       gnt_n;
  logic [1:0]       arb_gnt;
  logic             arb_ptr;
  logic             win_op;
  logic             check_err;

  rr_arb2 u_arb (
    .req      (req),
    .ptr      (ptr),
    .grant    (arb_gnt),
    .ptr_next (arb_ptr)
  );

  assign win_op    = arb_gnt[1] ? op[1] : op[0];
  assign check_err = (Q != op_lat) | (Q == nQ);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    ptr_n    = ptr;
    op_lat_n = op_lat;
    s_n      = S;
    r_n      = R;
    gnt_n    = gnt;
    done_n   = 1'b0;
    err_n    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|req) begin
          state_n  = ST_DRIVE;
          gnt_n    = arb_gnt;
          ptr_n    = arb_ptr;
          op_lat_n = win_op;
          s_n      = (win_op == OP_SET);
          r_n      = (win_op == OP_RESET);
          cnt_n    = PULSE_LD;
        end
      end
      ST_DRIVE: begin
        if (cnt == '0) begin
          s_n = 1'b0;
          r_n = 1'b0;
          if (HAS_GAP) begin
            state_n = ST_RECOVER;
            cnt_n   = GAP_LD;
          end else begin
            state_n = ST_CHECK;
            done_n  = 1'b1;
            err_n   = check_err;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      ST_RECOVER: begin
        if (cnt == '0) begin
          state_n = ST_CHECK;
          done_n  = 1'b1;
          err_n   = check_err;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      ST_CHECK: begin
        state_n = ST_IDLE;
        gnt_n   = 2'b00;
      end
      default: begin
        state_n = ST_IDLE;
        gnt_n   = 2'b00;
        s_n     = 1'b0;
        r_n     = 1'b0;
      end
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  // Asynchronous reset drops S/R immediately and abandons any operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      ptr    <= 1'b0;
      op_lat <= OP_RESET;
      S      <= 1'b0;
      R      <= 1'b0;
      gnt    <= 2'b00;
      done   <= 1'b0;
      err    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      ptr    <= ptr_n;
      op_lat <= op_lat_n;
      S      <= s_n;
      R      <= r_n;
      gnt    <= gnt_n;
      done   <= done_n;
      err    <= err_n;
      busy   <= busy_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rsff_req_arbiter.sv
`default_nettype none
// ============================================================================
// tb_rsff_req_arbiter : directed table vectors plus reset and random-run checks
// Revision: 1.0
// ============================================================================
module tb_rsff_req_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: PULSE_W=2, GAP_W=1
  logic       rst;
  logic [1:0] req, op;
  logic       q, nq, s, r, done, err, busy;
  logic [1:0] gnt;
  logic       q_int;
  logic [1:0] mode;

  rsff_req_arbiter #(.PULSE_W(2), .GAP_W(1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .Q(q), .nQ(nq),
    .S(s), .R(r), .gnt(gnt), .done(done), .err(err), .busy(busy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)    q_int <= 1'b0;
    else if (s) q_int <= 1'b1;
    else if (r) q_int <= 1'b0;
  end

  // mode 0: healthy flip-flop, 1: Q stuck at 0, 2: Q=nQ=1
  always_comb begin
    q  = q_int;
    nq = ~q_int;
    case (mode)
      2'd1:    begin q = 1'b0; nq = 1'b1; end
      2'd2:    begin q = 1'b1; nq = 1'b1; end
      default: begin q = q_int; nq = ~q_int; end
    endcase
  end

  // Second instance: PULSE_W=1, GAP_W=0 for the random run
  logic       rst2;
  logic [1:0] req2, op2;
  logic       q2_int, s2, r2, done2, err2, busy2;
  logic [1:0] gnt2;

  rsff_req_arbiter #(.PULSE_W(1), .GAP_W(0), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst2), .req(req2), .op(op2), .Q(q2_int), .nQ(~q2_int),
    .S(s2), .R(r2), .gnt(gnt2), .done(done2), .err(err2), .busy(busy2)
  );

  always_ff @(posedge clk or posedge rst2) begin
    if (rst2)    q2_int <= 1'b0;
    else if (s2) q2_int <= 1'b1;
    else if (r2) q2_int <= 1'b0;
  end

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0] req;
    logic [1:0] op;
    logic [1:0] mode;
    logic [1:0] after;
    logic [1:0] exp_gnt;
    logic       exp_s;
    logic       exp_err;
  } vec_t;

  vec_t vecs[15];

  // Invariants on the main instance
  bit run_mon = 0;
  always @(negedge clk) begin
    if (run_mon && !rst) begin
      check("main_s_and_r", {7'd0, s & r}, 8'd0);
      check("main_gnt_11", {7'd0, gnt == 2'b11}, 8'd0);
    end
  end

  // Random-run monitor on the second instance
  bit run_mon2 = 0;
  logic done2_prev = 1'b0;
  logic [1:0] gnt2_prev = 2'b00;
  int done2_cnt = 0;
  int gnt2_cnt  = 0;
  always @(negedge clk) begin
    if (run_mon2) begin
      check("rand_s_and_r", {7'd0, s2 & r2}, 8'd0);
      check("rand_gnt_11", {7'd0, gnt2 == 2'b11}, 8'd0);
      check("rand_done_width", {7'd0, done2 & done2_prev}, 8'd0);
      if (done2) done2_cnt++;
      if (gnt2 != 2'b00 && gnt2_prev == 2'b00) gnt2_cnt++;
    end
    done2_prev = done2;
    gnt2_prev  = gnt2;
  end

  // One full operation: edge k samples req, then cycles k+1..k+5 are checked
  task automatic run_op(input int idx, input vec_t v);
    logic [6:0] exp;
    req  = v.req;
    op   = v.op;
    mode = v.mode;
    @(posedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      case (c)
        1, 2:    exp = {v.exp_gnt, v.exp_s, ~v.exp_s, 1'b0, 1'b0, 1'b1};
        3:       exp = {v.exp_gnt, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        4:       exp = {v.exp_gnt, 1'b0, 1'b0, 1'b1, v.exp_err, 1'b1};
        default: exp = 7'b0;
      endcase
      check($sformatf("op%0d_cyc%0d", idx, c), {1'b0, gnt, s, r, done, err, busy}, {1'b0, exp});
      if (c == 4) begin
        @(posedge clk);
        #1;
        req  = v.after;
        mode = 2'd0;
      end
    end
  endtask

  initial begin
    //          req    op     mode  after  gnt    S     err
    vecs[0]  = '{2'b11, 2'b10, 2'd0, 2'b10, 2'b01, 1'b0, 1'b0};
    vecs[1]  = '{2'b10, 2'b10, 2'd0, 2'b00, 2'b10, 1'b1, 1'b0};
    vecs[2]  = '{2'b01, 2'b01, 2'd0, 2'b00, 2'b01, 1'b1, 1'b0};
    vecs[3]  = '{2'b11, 2'b10, 2'd0, 2'b00, 2'b10, 1'b1, 1'b0};
    vecs[4]  = '{2'b11, 2'b10, 2'd0, 2'b00, 2'b01, 1'b0, 1'b0};
    vecs[5]  = '{2'b10, 2'b10, 2'd0, 2'b00, 2'b10, 1'b1, 1'b0};
    vecs[6]  = '{2'b10, 2'b00, 2'd0, 2'b00, 2'b10, 1'b0, 1'b0};
    vecs[7]  = '{2'b11, 2'b01, 2'd0, 2'b00, 2'b01, 1'b1, 1'b0};
    vecs[8]  = '{2'b01, 2'b01, 2'd1, 2'b00, 2'b01, 1'b1, 1'b1};
    vecs[9]  = '{2'b10, 2'b10, 2'd2, 2'b00, 2'b10, 1'b1, 1'b1};
    vecs[10] = '{2'b11, 2'b00, 2'd0, 2'b00, 2'b01, 1'b0, 1'b0};
    vecs[11] = '{2'b11, 2'b11, 2'd0, 2'b00, 2'b10, 1'b1, 1'b0};
    vecs[12] = '{2'b10, 2'b10, 2'd0, 2'b00, 2'b10, 1'b1, 1'b0};
    vecs[13] = '{2'b10, 2'b00, 2'd0, 2'b00, 2'b10, 1'b0, 1'b0};
    vecs[14] = '{2'b11, 2'b11, 2'd0, 2'b00, 2'b01, 1'b1, 1'b0};

    rst = 1'b1; req = 2'b00; op = 2'b00; mode = 2'd0;
    rst2 = 1'b1; req2 = 2'b00; op2 = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {1'b0, gnt, s, r, done, err, busy}, 8'd0);
    rst = 1'b0;
    run_mon = 1;

    for (int i = 0; i < 15; i++) run_op(i, vecs[i]);

    // Asynchronous reset during DRIVE
    req = 2'b01; op = 2'b01;
    @(posedge clk);
    @(negedge clk);
    check("rst_pre_drive", {3'd0, gnt, s, r, busy}, {3'd0, 2'b01, 1'b1, 1'b0, 1'b1});
    #2 rst = 1'b1;
    #1 check("rst_async_drop", {2'd0, gnt, s, r, busy, done}, 8'd0);
    req = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("rst_hold_%0d", i), {6'd0, done, busy}, 8'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_no_done_%0d", i), {6'd0, done, busy}, 8'd0);
    end
    run_op(100, vecs[2]);
    run_mon = 0;

    // Random run on the PULSE_W=1, GAP_W=0 instance
    @(negedge clk);
    rst2 = 1'b0;
    run_mon2 = 1;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      req2 = 2'($urandom_range(0, 3));
      op2  = 2'($urandom_range(0, 3));
    end
    req2 = 2'b00;
    repeat (10) @(posedge clk);
    @(negedge clk);
    run_mon2 = 0;
    check("rand_done_eq_grant", 8'(done2_cnt - gnt2_cnt), 8'd0);
    check("rand_some_grants", {7'd0, gnt2_cnt > 50}, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/rsff_req_arbiter.md
Name: rsff_req_arbiter

Overview:
Controller that shares one clocked RS flip-flop (inputs S, R; outputs Q, nQ) between two requesters. Each requester asks for a SET or RESET operation. The block arbitrates round-robin and drives S/R as a clean pulse, never with S and R both high. It then waits a recovery gap, checks the Q/nQ feedback, and reports done/err to the granted requester. It sits between the requester logic and the RS flip-flop instance; S/R connect directly to the flip-flop, and Q/nQ come back from it.

Parameters:
PULSE_W, 2, cycles S or R is held high per operation (legal range >=1)
GAP_W, 1, recovery cycles with S=R=0 before the check (legal range >=0)
CNT_W, 4, width of the shared phase counter; must satisfy 2^CNT_W > max(PULSE_W, GAP_W)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req  input  2  per-requester request; bit i = requester i
op  input  2  per-requester operation, sampled with req; 1=SET, 0=RESET
Q  input  1  flip-flop true output (feedback)
nQ  input  1  flip-flop complement output (feedback)
S  output  1  flip-flop set drive
R  output  1  flip-flop reset drive
gnt  output  2  one-hot grant, held for the whole transaction
done  output  1  one-cycle completion strobe for the granted requester
err  output  1  valid only with done; 1 = feedback mismatch
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, S=0, R=0, gnt=2'b00, done=0, err=0, busy=0, rr pointer=0 (requester 0 has priority). All outputs are registered.
- Reset mid-operation: S/R drop immediately (asynchronously). The operation is abandoned and no done is issued.
- Invariant: S & R == 0 in every cycle.
- FSM states: IDLE, DRIVE, RECOVER, CHECK.
- IDLE:
  - If |req at edge k: grant the winner and latch op[winner].
  - From cycle k+1: state=DRIVE, gnt one-hot set, S=op or R=~op, counter loaded with PULSE_W-1.
- Arbitration:
  - A single requester wins outright.
  - If both request, the requester at the rr pointer wins.
  - The pointer moves to the other requester at each grant, whether or not there was contention.
- DRIVE: holds S/R for PULSE_W cycles. Then:
  - GAP_W>0: go to RECOVER, S=R=0, counter loaded with GAP_W-1.
  - GAP_W==0: go to CHECK.
- RECOVER: lasts GAP_W cycles, then CHECK.
- CHECK: one cycle.
  - done=1.
  - err=(Q!=latched op) | (Q==nQ), using Q/nQ sampled at the last RECOVER/DRIVE edge.
  - Next state: IDLE; gnt clears with the same edge.
- Latency: req sampled at edge k -> done high in cycle k+1+PULSE_W+GAP_W. The next grant is earliest at cycle k+3+PULSE_W+GAP_W (one IDLE cycle between operations).
- Request handling: a requester holds req until done. Deasserting req or changing op mid-transaction is ignored; the latched op completes. A losing requester keeps waiting; there is no timeout.
- busy = (state!=IDLE).

Decomposition:
- Shared package/include rsff_ctrl_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_DRIVE=2'd1, ST_RECOVER=2'd2, ST_CHECK=2'd3
  - OP_RESET=1'b0, OP_SET=1'b1
- One natural sub-module: rr_arb2 (2-way round-robin arbiter).
  - Inputs: req, pointer. Outputs: one-hot grant, next pointer.
  - Purely combinational; the pointer register lives in the parent.

Test Plan:
1. Reset, then req=2'b01, op=2'b01 at edge k -> gnt=01 and S=1 in cycles k+1..k+2; S=R=0 in k+3; done=1, err=0 in k+4 (flip-flop model connected); gnt=00 in k+5.
2. req=2'b11 from reset with op=2'b10 -> requester 0 granted first (R pulse, Q->0, done err=0). Requester 1 is then granted in the cycle after IDLE (S pulse, Q->1). gnt is never 2'b11.
3. Requester 1 alone twice, then both together -> the pointer alternates, so the contended grant goes to requester 0. Check across 6 back-to-back operations that gnt alternates.
4. Q tied to 0 and op=SET -> done=1, err=1. Separately, Q=nQ=1 forced with op=SET -> err=1.
5. Assert rst during DRIVE with S=1 -> S=0 and gnt=00 without waiting for a clock edge, and no done. After release, a fresh req completes normally.
6. Over a randomized 1000-cycle run with PULSE_W=1, GAP_W=0 -> S&R never both 1, done is exactly 1 cycle, and the done count equals the grant count.
